// File: rtl/obi_sram_arb_shim.sv
// Round-robin arbiter from NumPorts OBI subordinate ports onto one single-ported SRAM.
// Responses travel a fixed-latency return pipeline and land in per-port fall-through FIFOs.

module obi_sram_arb_shim_rsp #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1,
  parameter int RspDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  input  logic [IdWidth-1:0]   in_id,
  input  logic                 in_err,
  input  logic                 rready,
  output logic                 avail,
  output logic                 rvalid,
  output logic [DataWidth-1:0] rdata,
  output logic [IdWidth-1:0]   rid,
  output logic                 err
);
  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CntW = $clog2(RspDepth + 1);
  localparam int EntW = DataWidth + IdWidth + 1;

  logic [RspDepth-1:0][EntW-1:0] mem;
  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] used, cnt;
  logic            empty, push, pop, dec;
  logic [EntW-1:0] in_ent, head;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty  = (used == '0);
  assign in_ent = {in_data, in_id, in_err};
  // Empty FIFO lets the exiting beat fall straight through to the port.
  assign head   = empty ? in_ent : mem[rd_ptr];
  assign rvalid = !rst_i && (!empty || in_valid);
  assign push   = in_valid && (!empty || !rready);
  assign pop    = !empty && rready;
  assign dec    = rvalid && rready;
  assign {rdata, rid, err} = rvalid ? head : '0;
  assign avail  = (cnt < CntW'(RspDepth));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_ent;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   used <= used + CntW'(1);
        2'b01:   used <= used - CntW'(1);
        default: ;
      endcase
      // Outstanding = granted but not yet accepted; bounds FIFO occupancy.
      case ({inc, dec})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: ;
      endcase
    end
  end
endmodule

module obi_sram_arb_shim #(
  parameter int NumPorts    = 2,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int IdWidth     = 1,
  parameter int SramLatency = 1,
  parameter int RspDepth    = 2,
  parameter int NumWords    = 512
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             gnt_o,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0] be_i,
  input  logic [NumPorts*IdWidth-1:0]     aid_i,
  output logic [NumPorts-1:0]             rvalid_o,
  input  logic [NumPorts-1:0]             rready_i,
  output logic [NumPorts*DataWidth-1:0]   rdata_o,
  output logic [NumPorts*IdWidth-1:0]     rid_o,
  output logic [NumPorts-1:0]             err_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [AddrWidth-1:0]            sram_addr_o,
  output logic [DataWidth-1:0]            sram_wdata_o,
  output logic [DataWidth/8-1:0]          sram_be_o,
  input  logic                            sram_gnt_i,
  input  logic [DataWidth-1:0]            sram_rdata_i
);
  localparam int Bytes  = DataWidth / 8;
  localparam int PortW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int Stages = SramLatency;

  typedef struct packed {
    logic             vld;
    logic [PortW-1:0] port;
    logic [IdWidth-1:0] aid;
    logic             we;
    logic             err;
  } beat_t;

  logic [NumPorts-1:0][AddrWidth-1:0] addr_a;
  logic [NumPorts-1:0][DataWidth-1:0] wdata_a;
  logic [NumPorts-1:0][Bytes-1:0]     be_a;
  logic [NumPorts-1:0][IdWidth-1:0]   aid_a;
  logic [NumPorts-1:0] avail, elig, exit_vld;
  logic [PortW-1:0]    rr, win;
  logic                any, oor, grant;
  logic [AddrWidth-1:0] waddr;
  logic [AddrWidth:0]   word_idx;
  logic [DataWidth-1:0] exit_data;
  beat_t               beat_in, exit_b;
  beat_t [Stages:1]    pipe_q;
  int                  idx;

  assign addr_a  = addr_i;
  assign wdata_a = wdata_i;
  assign be_a    = be_i;
  assign aid_a   = aid_i;
  assign elig    = req_i & avail & {NumPorts{!rst_i}};

  // Lowest eligible index at or after rr, wrapping.
  always_comb begin
    win = rr;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = (int'(rr) + i) % NumPorts;
      if (!any && elig[idx]) begin
        any = 1'b1;
        win = PortW'(idx);
      end
    end
  end

  assign waddr    = addr_a[win];
  assign word_idx = {1'b0, waddr / AddrWidth'(Bytes)};
  assign oor      = (word_idx >= (AddrWidth + 1)'(NumWords));
  // Out-of-range beats never touch the SRAM and are accepted unconditionally.
  assign grant    = any && (oor || sram_gnt_i);

  assign sram_req_o   = any && !oor;
  assign sram_we_o    = sram_req_o && we_i[win];
  assign sram_addr_o  = sram_req_o ? waddr : '0;
  assign sram_wdata_o = sram_req_o ? wdata_a[win] : '0;
  assign sram_be_o    = sram_req_o ? be_a[win] : '0;

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr <= '0;
    else if (grant) rr <= (win == PortW'(NumPorts - 1)) ? '0 : win + PortW'(1);
  end

  assign beat_in = '{vld: grant, port: win, aid: aid_a[win], we: we_i[win], err: oor};

  always_ff @(posedge clk_i) begin
    for (int s = Stages; s > 1; s--) pipe_q[s] <= pipe_q[s-1];
    pipe_q[1] <= beat_in;
    if (rst_i) begin
      for (int s = 1; s <= Stages; s++) pipe_q[s].vld <= 1'b0;
    end
  end

  assign exit_b    = pipe_q[Stages];
  assign exit_data = (exit_b.we || exit_b.err) ? '0 : sram_rdata_i;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign exit_vld[p] = exit_b.vld && (exit_b.port == PortW'(p)) && !rst_i;

    obi_sram_arb_shim_rsp #(
      .DataWidth(DataWidth),
      .IdWidth  (IdWidth),
      .RspDepth (RspDepth)
    ) u_rsp (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc     (gnt_o[p] && req_i[p]),
      .in_valid(exit_vld[p]),
      .in_data (exit_data),
      .in_id   (exit_b.aid),
      .in_err  (exit_b.err),
      .rready  (rready_i[p]),
      .avail   (avail[p]),
      .rvalid  (rvalid_o[p]),
      .rdata   (rdata_o[p*DataWidth +: DataWidth]),
      .rid     (rid_o[p*IdWidth +: IdWidth]),
      .err     (err_o[p])
    );
  end
endmodule

// File: tb/tb_obi_sram_arb_shim.sv
// Directed bench: three shims (SramLatency 1,2,3) share stimulus; each scenario checks one of them.
module tb_obi_sram_arb_shim;
  localparam int NP = 2, AW = 32, DW = 32, IW = 1, ND = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [NP-1:0] req = '0, we = '0, rready = '1, aid = '0;
  logic [NP-1:0][AW-1:0] addr = '0;
  logic [NP-1:0][DW-1:0] wdata = '0;
  logic [NP-1:0][DW/8-1:0] be = '1;
  logic sram_gnt = 1'b0;
  logic [DW-1:0] sram_rdata = '0;

  logic [ND-1:0][NP-1:0] gnt, rvalid, err, rid;
  logic [ND-1:0][NP*DW-1:0] rdata;
  logic [ND-1:0] sram_req, sram_we;
  logic [ND-1:0][AW-1:0] sram_addr;
  logic [ND-1:0][DW-1:0] sram_wdata;
  logic [ND-1:0][DW/8-1:0] sram_be;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    obi_sram_arb_shim #(
      .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW),
      .SramLatency(g + 1), .RspDepth(2), .NumWords(512)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[g]), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be), .aid_i(aid),
      .rvalid_o(rvalid[g]), .rready_i(rready), .rdata_o(rdata[g]), .rid_o(rid[g]),
      .err_o(err[g]), .sram_req_o(sram_req[g]), .sram_we_o(sram_we[g]),
      .sram_addr_o(sram_addr[g]), .sram_wdata_o(sram_wdata[g]), .sram_be_o(sram_be[g]),
      .sram_gnt_i(sram_gnt), .sram_rdata_i(sram_rdata)
    );
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; we = '0; rready = '1; sram_gnt = 1'b0; aid = '0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset; #1;
    for (int g = 0; g < ND; g++) begin
      checks++; if (gnt[g] !== 2'b00) begin errors++; $display("FAIL rst_gnt dut%0d: got %b want 00", g, gnt[g]); end
      checks++; if (rvalid[g] !== 2'b00) begin errors++; $display("FAIL rst_rvalid dut%0d: got %b want 00", g, rvalid[g]); end
      checks++; if (sram_req[g] !== 1'b0) begin errors++; $display("FAIL rst_sram_req dut%0d: got %b want 0", g, sram_req[g]); end
    end
  endtask

  task automatic test_read;
    do_reset;
    req = 2'b01; we = '0; addr[0] = 32'h10; aid = 2'b01; sram_gnt = 1'b1; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b want 01", gnt[0]); end
    checks++; if (sram_req[0] !== 1'b1) begin errors++; $display("FAIL rd_sram_req: got %b want 1", sram_req[0]); end
    checks++; if (sram_addr[0] !== 32'h10) begin errors++; $display("FAIL rd_sram_addr: got %h want 10", sram_addr[0]); end
    step; req = '0; sram_rdata = 32'hCAFE; #1;
    checks++; if (rvalid[0] !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", rvalid[0]); end
    checks++; if (rdata[0][31:0] !== 32'hCAFE) begin errors++; $display("FAIL rd_rdata: got %h want cafe", rdata[0][31:0]); end
    checks++; if (rid[0] !== 2'b01) begin errors++; $display("FAIL rd_rid: got %b want 01", rid[0]); end
    checks++; if (err[0] !== 2'b00) begin errors++; $display("FAIL rd_err: got %b want 00", err[0]); end
    step; #1;
    checks++; if (rvalid[0] !== 2'b00) begin errors++; $display("FAIL rd_idle_rvalid: got %b want 00", rvalid[0]); end
    checks++; if (rdata[0] !== '0) begin errors++; $display("FAIL rd_idle_rdata: got %h want 0", rdata[0]); end
  endtask

  task automatic test_write;
    do_reset;
    req = 2'b10; we = 2'b10; addr[1] = 32'h20; wdata[1] = 32'h1234_5678; be[1] = 4'b0011;
    sram_gnt = 1'b1; #1;
    checks++; if (gnt[0] !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", gnt[0]); end
    checks++; if (sram_we[0] !== 1'b1) begin errors++; $display("FAIL wr_sram_we: got %b want 1", sram_we[0]); end
    checks++; if (sram_wdata[0] !== 32'h1234_5678) begin errors++; $display("FAIL wr_sram_wdata: got %h want 12345678", sram_wdata[0]); end
    checks++; if (sram_be[0] !== 4'b0011) begin errors++; $display("FAIL wr_sram_be: got %b want 0011", sram_be[0]); end
    checks++; if (sram_addr[0] !== 32'h20) begin errors++; $display("FAIL wr_sram_addr: got %h want 20", sram_addr[0]); end
    step; req = '0; we = '0; be = '1; sram_rdata = 32'h5555; #1;
    checks++; if (rvalid[0] !== 2'b10) begin errors++; $display("FAIL wr_rvalid: got %b want 10", rvalid[0]); end
    checks++; if (rdata[0][63:32] !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rdata[0][63:32]); end
    checks++; if (err[0] !== 2'b00) begin errors++; $display("FAIL wr_err: got %b want 00", err[0]); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    do_reset;
    req = 2'b11; addr[0] = 32'h0; addr[1] = 32'h4; sram_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (gnt[0] !== exp) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt[0], exp); end
      step;
    end
    sram_gnt = 1'b0; #1;
    checks++; if (gnt[0] !== 2'b00) begin errors++; $display("FAIL rr_stall_gnt: got %b want 00", gnt[0]); end
    checks++; if (sram_req[0] !== 1'b1) begin errors++; $display("FAIL rr_stall_req: got %b want 1", sram_req[0]); end
    step; sram_gnt = 1'b1; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL rr_hold_gnt: got %b want 01", gnt[0]); end
    step; #1;
    checks++; if (gnt[0] !== 2'b10) begin errors++; $display("FAIL rr_after_gnt: got %b want 10", gnt[0]); end
    step; req = '0;
  endtask

  task automatic test_backpressure;
    do_reset;
    rready = 2'b10; req = 2'b01; addr[0] = 32'h100; aid = '0; sram_gnt = 1'b1; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL bp_gnt_a: got %b want 01", gnt[0]); end
    step; sram_rdata = 32'h111; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL bp_gnt_b: got %b want 01", gnt[0]); end
    checks++; if (rvalid[0] !== 2'b01 || rdata[0][31:0] !== 32'h111) begin errors++; $display("FAIL bp_ft_a: got %b/%h want 01/111", rvalid[0], rdata[0][31:0]); end
    step; sram_rdata = 32'h222; #1;
    checks++; if (gnt[0] !== 2'b00) begin errors++; $display("FAIL bp_full_gnt: got %b want 00", gnt[0]); end
    checks++; if (sram_req[0] !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %b want 0", sram_req[0]); end
    checks++; if (rvalid[0] !== 2'b01 || rdata[0][31:0] !== 32'h111) begin errors++; $display("FAIL bp_head_a: got %b/%h want 01/111", rvalid[0], rdata[0][31:0]); end
    step; sram_rdata = 32'h999; rready = 2'b11; #1;
    checks++; if (gnt[0] !== 2'b00) begin errors++; $display("FAIL bp_pop_gnt: got %b want 00", gnt[0]); end
    checks++; if (rvalid[0] !== 2'b01 || rdata[0][31:0] !== 32'h111) begin errors++; $display("FAIL bp_pop_a: got %b/%h want 01/111", rvalid[0], rdata[0][31:0]); end
    step; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL bp_gnt_c: got %b want 01", gnt[0]); end
    checks++; if (rvalid[0] !== 2'b01 || rdata[0][31:0] !== 32'h222) begin errors++; $display("FAIL bp_head_b: got %b/%h want 01/222", rvalid[0], rdata[0][31:0]); end
    step; req = '0; sram_rdata = 32'h333; #1;
    checks++; if (rvalid[0] !== 2'b01 || rdata[0][31:0] !== 32'h333) begin errors++; $display("FAIL bp_ft_c: got %b/%h want 01/333", rvalid[0], rdata[0][31:0]); end
    step; #1;
    checks++; if (rvalid[0] !== 2'b00) begin errors++; $display("FAIL bp_drained: got %b want 00", rvalid[0]); end
  endtask

  task automatic test_out_of_range;
    do_reset;
    req = 2'b01; we = '0; addr[0] = 32'h7FC; aid = 2'b01; sram_gnt = 1'b0; #1;
    checks++; if (sram_req[0] !== 1'b1) begin errors++; $display("FAIL oor_last_req: got %b want 1", sram_req[0]); end
    checks++; if (gnt[0] !== 2'b00) begin errors++; $display("FAIL oor_last_nognt: got %b want 00", gnt[0]); end
    step; sram_gnt = 1'b1; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL oor_last_gnt: got %b want 01", gnt[0]); end
    step; addr[0] = 32'h800; sram_gnt = 1'b0; sram_rdata = 32'h7777; #1;
    checks++; if (gnt[0] !== 2'b01) begin errors++; $display("FAIL oor_gnt: got %b want 01", gnt[0]); end
    checks++; if (sram_req[0] !== 1'b0) begin errors++; $display("FAIL oor_sram_req: got %b want 0", sram_req[0]); end
    checks++; if (rvalid[0] !== 2'b01 || rdata[0][31:0] !== 32'h7777 || err[0] !== 2'b00) begin errors++; $display("FAIL oor_last_rsp: got %b/%h/%b want 01/7777/00", rvalid[0], rdata[0][31:0], err[0]); end
    step; req = '0; sram_rdata = 32'hDEAD; #1;
    checks++; if (rvalid[0] !== 2'b01) begin errors++; $display("FAIL oor_rvalid: got %b want 01", rvalid[0]); end
    checks++; if (err[0] !== 2'b01) begin errors++; $display("FAIL oor_err: got %b want 01", err[0]); end
    checks++; if (rdata[0] !== '0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rdata[0]); end
    checks++; if (rid[0] !== 2'b01) begin errors++; $display("FAIL oor_rid: got %b want 01", rid[0]); end
    step; #1;
    checks++; if (err[0] !== 2'b00 || rvalid[0] !== 2'b00) begin errors++; $display("FAIL oor_idle: got %b/%b want 00/00", err[0], rvalid[0]); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    req = 2'b10; we = '0; addr[1] = 32'h40; aid = 2'b10; sram_gnt = 1'b1; #1;
    checks++; if (gnt[2] !== 2'b10) begin errors++; $display("FAIL b2b_gnt0: got %b want 10", gnt[2]); end
    step; addr[1] = 32'h44; aid = 2'b00; #1;
    checks++; if (gnt[2] !== 2'b10) begin errors++; $display("FAIL b2b_gnt1: got %b want 10", gnt[2]); end
    step; req = '0; #1;
    checks++; if (rvalid[2] !== 2'b00) begin errors++; $display("FAIL b2b_early: got %b want 00", rvalid[2]); end
    step; sram_rdata = 32'hA1; #1;
    checks++; if (rvalid[2] !== 2'b10 || rdata[2][63:32] !== 32'hA1 || rid[2] !== 2'b10) begin errors++; $display("FAIL b2b_rsp0: got %b/%h/%b want 10/a1/10", rvalid[2], rdata[2][63:32], rid[2]); end
    step; sram_rdata = 32'hA2; #1;
    checks++; if (rvalid[2] !== 2'b10 || rdata[2][63:32] !== 32'hA2 || rid[2] !== 2'b00) begin errors++; $display("FAIL b2b_rsp1: got %b/%h/%b want 10/a2/00", rvalid[2], rdata[2][63:32], rid[2]); end
    step; #1;
    checks++; if (rvalid[2] !== 2'b00) begin errors++; $display("FAIL b2b_done: got %b want 00", rvalid[2]); end
  endtask

  task automatic test_reset_inflight;
    do_reset;
    req = 2'b01; we = '0; addr[0] = 32'h8; sram_gnt = 1'b1; #1;
    checks++; if (gnt[1] !== 2'b01) begin errors++; $display("FAIL rif_gnt: got %b want 01", gnt[1]); end
    step; req = '0; rst = 1'b1;
    step; rst = 1'b0; #1;
    checks++; if (rvalid[1] !== 2'b00) begin errors++; $display("FAIL rif_dropped: got %b want 00", rvalid[1]); end
    step; rready = 2'b00; req = 2'b01; #1;
    checks++; if (rvalid[1] !== 2'b00) begin errors++; $display("FAIL rif_quiet: got %b want 00", rvalid[1]); end
    checks++; if (gnt[1] !== 2'b01) begin errors++; $display("FAIL rif_cnt_g1: got %b want 01", gnt[1]); end
    step; #1;
    checks++; if (gnt[1] !== 2'b01) begin errors++; $display("FAIL rif_cnt_g2: got %b want 01", gnt[1]); end
    step; #1;
    checks++; if (gnt[1] !== 2'b00) begin errors++; $display("FAIL rif_cnt_full: got %b want 00", gnt[1]); end
    step; req = '0; rready = '1;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_round_robin;
    test_backpressure;
    test_out_of_range;
    test_back_to_back;
    test_reset_inflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_sram_arb_shim.md
OBI_SRAM_ARB_SHIM -- requirements
Module: obi_sram_arb_shim

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of OBI subordinate ports, 1..8.
REQ-002 SHALL have parameter AddrWidth, default 32: OBI byte-address width.
REQ-003 SHALL have parameter DataWidth, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter IdWidth, default 1: aid/rid width.
REQ-005 SHALL have parameter SramLatency, default 1: cycles from SRAM grant to rdata_i valid, 1..4.
REQ-006 SHALL have parameter RspDepth, default 2: per-port response FIFO depth, at least 1.
REQ-007 SHALL have parameter NumWords, default 512: SRAM size in DataWidth words.
REQ-008 SHALL use one clock and a synchronous, active-high reset.
REQ-009 SHALL have these ports, one per line: name  direction  width  meaning.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  NumPorts  per-port OBI request.
- gnt_o  out  NumPorts  per-port OBI grant.
- we_i  in  NumPorts  write enable.
- addr_i  in  NumPorts*AddrWidth  byte addresses.
- wdata_i  in  NumPorts*DataWidth  write data.
- be_i  in  NumPorts*DataWidth/8  byte enables.
- aid_i  in  NumPorts*IdWidth  transaction IDs.
- rvalid_o  out  NumPorts  response valid.
- rready_i  in  NumPorts  response ready.
- rdata_o  out  NumPorts*DataWidth  read data.
- rid_o  out  NumPorts*IdWidth  response ID.
- err_o  out  NumPorts  response error.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  byte address of winner.
- sram_wdata_o  out  DataWidth  write data.
- sram_be_o  out  DataWidth/8  byte enables.
- sram_gnt_i  in  1  SRAM accepts request.
- sram_rdata_i  in  DataWidth  read data, valid SramLatency cycles after grant.

Function
REQ-010 Port p SHALL be eligible when req_i[p]=1 and its outstanding count is below RspDepth.
REQ-011 The arbiter SHALL be round-robin; the search starts at pointer rr and the lowest index at or after rr (wrapping) wins.
REQ-012 On any grant, rr SHALL become (winner+1) mod NumPorts; with no grant, rr SHALL hold.
REQ-013 In-range handling: the winner SHALL drive sram_* combinationally, with sram_req_o=1; gnt_o[winner]=sram_gnt_i; all other gnt_o bits SHALL be 0.
REQ-014 A request SHALL be out of range if addr/(DataWidth/8) >= NumWords.
REQ-015 Out-of-range handling: sram_req_o SHALL be 0, gnt_o[winner]=1 in the same cycle, and the response SHALL carry err_o=1 and rdata_o=0.
REQ-016 Each granted beat SHALL enter a SramLatency-stage shift pipeline carrying {valid, port, aid, we, err}.
REQ-017 Beats SHALL leave the pipeline in grant order, exactly SramLatency cycles after the grant cycle T.
REQ-018 At pipeline exit (cycle T+SramLatency), response data SHALL be: sram_rdata_i for a read, 0 for a write or error.
REQ-019 If the target port FIFO is empty at exit, the response SHALL appear combinationally (fall-through) with rvalid_o=1 in cycle T+SramLatency.
REQ-020 A response not consumed in the exit cycle (rready_i=0), or arriving while the FIFO is non-empty, SHALL be stored in the FIFO.
REQ-021 Each port SHALL present its FIFO head until rvalid_o&rready_i; responses SHALL stay in order.
REQ-022 rdata_o, rid_o and err_o SHALL be 0 whenever rvalid_o=0.
REQ-023 The per-port outstanding count SHALL be incremented on gnt_o&req_i and decremented on rvalid_o&rready_i; both in one cycle leaves it unchanged.
REQ-024 A port SHALL be ineligible when its count equals RspDepth, so the FIFO never overflows.
REQ-025 The outstanding count SHALL never exceed RspDepth or underflow.
REQ-026 If sram_gnt_i=0, no in-range grant SHALL occur and rr SHALL hold; the request stays stable per OBI.
REQ-027 A port may be granted in consecutive cycles, subject to REQ-010.

Reset
REQ-028 While rst_i=1 at a clock edge: rr SHALL be 0, all pipeline valids and outstanding counts SHALL be 0, and all FIFOs SHALL be empty.
REQ-029 In the cycle after reset, all gnt_o, rvalid_o and sram_req_o SHALL be 0 unless new requests are present.
REQ-030 Beats in flight at reset SHALL be discarded and SHALL produce no response.

Verification
REQ-031 Scenario: NumPorts=2, SramLatency=1, port0 reads addr 0x10, sram_gnt_i=1, sram_rdata_i=0xCAFE at T+1 -> rvalid_o[0]=1 at T+1, rdata_o=0xCAFE, rid=aid, err=0.
REQ-032 Scenario: both ports request continuously, rr=0 -> grants alternate 0,1,0,1.
REQ-033 Scenario: RspDepth=2, rready_i[0]=0, port0 issues 3 reads -> 2 granted, 3rd gnt_o[0]=0 until one response is accepted; data returns in order.
REQ-034 Scenario: read at addr 4*NumWords -> sram_req_o=0, gnt_o=1, response err_o=1, rdata_o=0.
REQ-035 Scenario: SramLatency=3, back-to-back reads from port1 -> rvalid_o[1] at T+3 and T+4 with the matching data.
REQ-036 Scenario: rst_i asserted one cycle after a grant with SramLatency=2 -> no rvalid_o afterwards, counts 0.
